e_mdu_sequencer: RTL and testbench
==================================

// Module: e_mdu_sequencer
// PURPOSE
//  Execute-stage multiply/divide unit with its own sequencer. Owns HI/LO and
//  models fixed MULT/DIV latency with an FSM and a down-counter. Drives the
//  busy/stall request that holds an MD instruction in D while an op is in flight.
//  Sits beside E_ALU; M-stage reads mfhi/mflo results from md_out.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk        in   1   system clock, single clock domain
//  reset      in   1   synchronous, active-high
//  start      in   1   E-stage instruction is a valid MD op this cycle
//  md_op      in   4   op code: `md_mult/`md_multu/`md_div/`md_divu/`md_mthi/`md_mtlo/`md_mfhi/`md_mflo
//  a          in   32  forwarded rs value
//  b          in   32  forwarded rt value
//  busy       out  1   registered; 1 while a mult/div is in flight
//  stall_req  out  1   combinational: busy | (start & op is mult/multu/div/divu)
//  hi         out  32  architectural HI register
//  lo         out  32  architectural LO register
//  md_out     out  32  mfhi -> hi, mflo -> lo, else 0 (combinational from md_op)
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending hi/lo=0. Reset
//    mid-operation aborts the op; HI/LO return to 0, no commit.
//  - FSM states: IDLE, MULT, DIV.
//    IDLE & start & mult/multu -> MULT, cnt<=MULT_CYCLES-1, busy<=1.
//    IDLE & start & div/divu   -> DIV,  cnt<=DIV_CYCLES-1,  busy<=1.
//    MULT/DIV & cnt!=0 -> cnt<=cnt-1.  cnt==0 -> commit pending to hi/lo,
//    busy<=0, -> IDLE. So hi/lo update at end of busy's last cycle; an op
//    started at edge N is visible after edge N+LAT (LAT = param value).
//  - Operands sampled at start edge; result computed then into pending regs:
//    mult: {hi,lo}=$signed(a)*$signed(b) (64b); multu: unsigned 64b product.
//    div: lo=$signed(a)/$signed(b), hi=$signed(a)%$signed(b) (remainder sign
//    follows dividend); divu: unsigned quotient/remainder.
//  - Divide by zero (b==0): op still takes DIV_CYCLES, busy behaves normally,
//    HI/LO left unchanged at commit.
//  - mthi: hi<=a next edge; mtlo: lo<=a next edge; no busy, 1-cycle.
//  - mfhi/mflo: pure read, no state change.
//  - start while busy=1: ignored entirely (no state change, no hi/lo write).
//    Pipeline guarantees this via stall_req; verification checks robustness.
//  - mthi/mtlo while busy: ignored (in-flight commit wins).
//  - Unknown md_op with start: no effect.
// STRUCTURE
//  - `md_* op codes added to const.v next to `alu_* codes; 4-bit field.
//  - Sub-module md_latency_counter: load value, dec, zero flag; width
//    $clog2(max(MULT_CYCLES,DIV_CYCLES))+1. FSM, pending regs, HI/LO in top.
// TESTING
//  1 reset; mult a=-3 b=7 -> busy=1 for 5 cycles, then hi=32'hFFFFFFFF,
//    lo=32'hFFFFFFEB; stall_req high on start cycle and all busy cycles.
//  2 multu a=32'hFFFFFFFF b=2 -> after 5 cycles hi=1, lo=32'hFFFFFFFE.
//  3 div a=-7 b=2 -> busy 10 cycles, then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF;
//    divu a=7 b=2 -> lo=3, hi=1.
//  4 mthi a=5 then div a=9 b=0 -> 10 busy cycles, hi stays 5, lo unchanged.
//  5 mult in flight, assert start with div and mtlo a=1 on cycles 2,3 ->
//    ignored; only mult result commits; busy drops after cycle 5.
//  6 div in flight, reset on cycle 4 -> next edge busy=0, hi=lo=0; mflo
//    then gives md_out=0; new mult after reset completes normally.

Source files
------------

// File: rtl/e_mdu_sequencer_pkg.sv
// Shared op codes, FSM states and result record for the execute-stage mul/div unit.
// Op code 0 is reserved as "no MD op" so an idle decode field never triggers anything.
package e_mdu_sequencer_pkg;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MFHI  = 4'd7;
   localparam logic [3:0] MD_MFLO  = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DIV  = 2'd2
   } md_state_t;

   typedef struct packed {
      logic        wr;
      logic [31:0] hi;
      logic [31:0] lo;
   } md_res_t;

   function automatic logic is_long_op(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/e_mdu_sequencer_md_latency_counter.sv
// Loadable down-counter timing an in-flight mult/div; saturates at zero.
// Latency: load/dec take effect on the next edge; zero flag is combinational from the count.
module e_mdu_sequencer_md_latency_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/e_mdu_sequencer.sv
// Execute-stage multiply/divide unit: owns HI/LO, models fixed MULT/DIV latency, raises stall.
// Results are computed at the start edge and held in a pending record until the count expires.
module e_mdu_sequencer
   import e_mdu_sequencer_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_out
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;

   md_state_t     state, state_n;
   md_res_t       pend, res;
   logic          cnt_load, cnt_dec, cnt_zero, commit, accept;
   logic [CW-1:0] cnt_load_val, cnt;
   logic          mthi_we, mtlo_we;
   logic [63:0]   prod_s, prod_u;
   logic [31:0]   divisor, quot_s, rem_s, quot_u, rem_u;

   e_mdu_sequencer_md_latency_counter #(.W(CW)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   // Divisor forced non-zero so the dividers never see x; a zero divide never writes back anyway.
   assign divisor = (b == 32'd0) ? 32'd1 : b;
   assign prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u  = {32'd0, a} * {32'd0, b};
   assign quot_s  = $signed(a) / $signed(divisor);
   assign rem_s   = $signed(a) % $signed(divisor);
   assign quot_u  = a / divisor;
   assign rem_u   = a % divisor;

   always_comb begin
      res = '0;
      case (md_op)
         MD_MULT:  res = '{wr: 1'b1, hi: prod_s[63:32], lo: prod_s[31:0]};
         MD_MULTU: res = '{wr: 1'b1, hi: prod_u[63:32], lo: prod_u[31:0]};
         MD_DIV:   res = '{wr: (b != 32'd0), hi: rem_s, lo: quot_s};
         MD_DIVU:  res = '{wr: (b != 32'd0), hi: rem_u, lo: quot_u};
         default:  res = '0;
      endcase
   end

   always_comb begin
      state_n      = state;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      commit       = 1'b0;
      accept       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && ((md_op == MD_MULT) || (md_op == MD_MULTU))) begin
               state_n      = ST_MULT;
               cnt_load     = 1'b1;
               cnt_load_val = CW'(MULT_CYCLES - 1);
               accept       = 1'b1;
            end else if (start && ((md_op == MD_DIV) || (md_op == MD_DIVU))) begin
               state_n      = ST_DIV;
               cnt_load     = 1'b1;
               cnt_load_val = CW'(DIV_CYCLES - 1);
               accept       = 1'b1;
            end
         end
         ST_MULT, ST_DIV: begin
            if (cnt_zero) begin
               commit  = 1'b1;
               state_n = ST_IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Moves to HI/LO only land while idle, so they can never collide with a commit.
   assign mthi_we = start && (state == ST_IDLE) && (md_op == MD_MTHI);
   assign mtlo_we = start && (state == ST_IDLE) && (md_op == MD_MTLO);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         pend  <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_n;
         busy  <= (state_n != ST_IDLE);
         if (accept) pend <= res;
         if (commit && pend.wr) begin
            hi <= pend.hi;
            lo <= pend.lo;
         end else begin
            if (mthi_we) hi <= a;
            if (mtlo_we) lo <= a;
         end
      end
   end

   assign stall_req = busy | (start & is_long_op(md_op));

   always_comb begin
      md_out = 32'd0;
      if (md_op == MD_MFHI) md_out = hi;
      else if (md_op == MD_MFLO) md_out = lo;
   end

endmodule

// File: tb/tb_e_mdu_sequencer.sv
// Scoreboard bench: issued mult/div ops queue their expected HI/LO; a monitor checks on each busy fall.
module tb_e_mdu_sequencer;
   import e_mdu_sequencer_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] a, b;
   logic        busy, stall_req;
   logic [31:0] hi, lo, md_out;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic prev_busy = 1'b0;

   e_mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .md_op     (md_op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo),
      .md_out    (md_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (prev_busy && !busy) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL commit_unexpected: busy fell with empty scoreboard");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("commit_hi", hi, e.hi);
            check("commit_lo", lo, e.lo);
         end
      end
      prev_busy = busy;
   end

   // Counts busy cycles (sampled at negedge) until busy drops; stall_req must track busy.
   task automatic wait_done(input string name, input int already, input int lat);
      int cyc;
      cyc = already;
      @(negedge clk);
      while (busy === 1'b1 && cyc < 60) begin
         if (stall_req !== 1'b1) check({name, "_stall_busy"}, {31'd0, stall_req}, 32'd1);
         cyc++;
         @(negedge clk);
      end
      check({name, "_busy_cycles"}, cyc, lat);
   endtask

   task automatic issue(input string name, input logic [3:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
      @(posedge clk); #1;
      exp_q.push_back('{hi: ehi, lo: elo});
      start = 1'b1; md_op = op; a = va; b = vb;
      @(negedge clk);
      check({name, "_stall_start"}, {31'd0, stall_req}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0; md_op = MD_NONE;
      wait_done(name, 0, lat);
   endtask

   task automatic move(input logic [3:0] op, input logic [31:0] va);
      @(posedge clk); #1;
      start = 1'b1; md_op = op; a = va; b = 32'd0;
      @(posedge clk); #1;
      start = 1'b0; md_op = MD_NONE;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; md_op = MD_NONE; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_stall", {31'd0, stall_req}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);

      issue("mult", MD_MULT, -32'sd3, 32'd7, 5, 32'hFFFFFFFF, 32'hFFFFFFEB);
      issue("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
      issue("div", MD_DIV, -32'sd7, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      issue("divu", MD_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);

      move(MD_MTHI, 32'd5);
      md_op = MD_MFHI; #1;
      check("mfhi_after_mthi", md_out, 32'd5);
      md_op = MD_MFLO; #1;
      check("mflo_keep", md_out, 32'd3);
      md_op = MD_NONE;
      issue("div0", MD_DIV, 32'd9, 32'd0, 10, 32'd5, 32'd3);

      // Unknown op code with start: no state change at all.
      @(posedge clk); #1;
      start = 1'b1; md_op = 4'hF; a = 32'hDEAD; b = 32'd1;
      @(negedge clk);
      check("unk_stall", {31'd0, stall_req}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0; md_op = MD_NONE;
      @(negedge clk);
      check("unk_busy", {31'd0, busy}, 32'd0);
      check("unk_hi", hi, 32'd5);
      check("unk_lo", lo, 32'd3);

      // Mult in flight; div and mtlo attempts on busy cycles 2 and 3 must be ignored.
      @(posedge clk); #1;
      exp_q.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF8});
      start = 1'b1; md_op = MD_MULT; a = 32'd4; b = -32'sd2;
      @(posedge clk); #1;
      start = 1'b0; md_op = MD_NONE;
      @(posedge clk); #1;
      start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd3;
      @(negedge clk);
      check("inflight_stall", {31'd0, stall_req}, 32'd1);
      @(posedge clk); #1;
      md_op = MD_MTLO; a = 32'd1;
      @(posedge clk); #1;
      start = 1'b0; md_op = MD_NONE;
      wait_done("inflight", 3, 5);
      repeat (3) @(negedge clk);
      check("inflight_idle", {31'd0, busy}, 32'd0);

      // Div aborted by reset on its 4th busy cycle.
      @(posedge clk); #1;
      exp_q.push_back('{hi: 32'd0, lo: 32'd0});
      start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; md_op = MD_NONE;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("abort_busy_pre", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      md_op = MD_MFLO; #1;
      check("abort_mflo", md_out, 32'd0);
      md_op = MD_NONE;
      issue("mult_after_rst", MD_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42);

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
